// File: rtl/ddr3_cont_cpu_rx.sv
// DDR3 controller CPU-side request receiver.
// Show-ahead FIFO of CPU requests {ADDR,BA,COL,CMD,WR_DATA} toward the scheduler,
// with a one-cycle-ahead CMD_RDY promise, halt freeze and sticky overflow flag.
// Optional macro DDR3_CONT_RX_STATS_EN builds saturating write/read push counters;
// without it wr_cnt and rd_cnt are tied to zero.
module ddr3_cont_cpu_rx #(
   parameter int DEPTH = 4
) (
   input  logic        cpu_clk,
   input  logic        reset,
   input  logic [14:0] ADDR,
   input  logic [2:0]  BA,
   input  logic [9:0]  COL,
   input  logic        CMD,
   input  logic [63:0] WR_DATA,
   input  logic        ADDR_VALID,
   output logic        CMD_RDY,
   input  logic        halt,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [14:0] req_addr,
   output logic [2:0]  req_ba,
   output logic [9:0]  req_col,
   output logic        req_cmd,
   output logic [63:0] req_wdata,
   output logic        ovf_err,
   output logic [15:0] wr_cnt,
   output logic [15:0] rd_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int EW = 15 + 3 + 10 + 1 + 64;

   typedef enum logic {RUN, HOLD} state_t;

   state_t            state, state_nxt;
   logic [EW-1:0]     mem [DEPTH];
   logic [EW-1:0]     last_head;
   logic [EW-1:0]     head;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [PW:0]       count;
   logic [PW+1:0]     cnt_plus_av;
   logic              full;
   logic              push, pop, ovf_hit;

   assign full        = (count == (PW+1)'(DEPTH));
   assign cnt_plus_av = {1'b0, count} + {{(PW+1){1'b0}}, ADDR_VALID};

   // Next state plus handshake decode; CMD_RDY ignores a same-cycle pop to stay conservative.
   always_comb begin
      state_nxt = state;
      CMD_RDY   = 1'b0;
      req_valid = 1'b0;
      pop       = 1'b0;
      push      = 1'b0;
      ovf_hit   = 1'b0;
      case (state)
         RUN:  if (halt)  state_nxt = HOLD;
         HOLD: if (!halt) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
      if (!reset) begin
         CMD_RDY   = (state == RUN) && (cnt_plus_av <= (PW+2)'(DEPTH - 1));
         req_valid = (state == RUN) && (count != '0);
         pop       = req_valid && req_ready;
         push      = ADDR_VALID && (!full || pop);
         ovf_hit   = ADDR_VALID && full && !pop;
      end
   end

   // State register.
   always_ff @(posedge cpu_clk) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   // Queue storage, pointers, occupancy, last-popped head and sticky overflow.
   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         last_head <= '0;
         ovf_err   <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {ADDR, BA, COL, CMD, WR_DATA};
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            last_head <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
         if (ovf_hit) ovf_err <= 1'b1;
      end
   end

   // Head fields stay at the last popped entry once the queue runs dry.
   assign head = (count != '0) ? mem[rd_ptr] : last_head;
   assign {req_addr, req_ba, req_col, req_cmd, req_wdata} = head;

`ifdef DDR3_CONT_RX_STATS_EN
   logic [15:0] wr_cnt_q, rd_cnt_q;

   // Saturating counts of accepted writes and reads.
   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else if (push) begin
         if (CMD && (wr_cnt_q != 16'hFFFF))  wr_cnt_q <= wr_cnt_q + 16'd1;
         if (!CMD && (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
   end

   assign wr_cnt = wr_cnt_q;
   assign rd_cnt = rd_cnt_q;
`else
   assign wr_cnt = '0;
   assign rd_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr3_cont_cpu_rx.sv
// Directed bench for ddr3_cont_cpu_rx: inputs change on the falling edge,
// outputs are checked on the falling edge, away from the rising active edge.
module tb_ddr3_cont_cpu_rx;

   logic        cpu_clk = 1'b0;
   logic        reset = 1'b0;
   logic [14:0] ADDR = '0;
   logic [2:0]  BA = '0;
   logic [9:0]  COL = '0;
   logic        CMD = 1'b0;
   logic [63:0] WR_DATA = '0;
   logic        ADDR_VALID = 1'b0;
   logic        CMD_RDY;
   logic        halt = 1'b0;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic [14:0] req_addr;
   logic [2:0]  req_ba;
   logic [9:0]  req_col;
   logic        req_cmd;
   logic [63:0] req_wdata;
   logic        ovf_err;
   logic [15:0] wr_cnt, rd_cnt;

   int errors = 0;
   int checks = 0;

   ddr3_cont_cpu_rx #(.DEPTH(4)) dut (
      .cpu_clk(cpu_clk), .reset(reset), .ADDR(ADDR), .BA(BA), .COL(COL), .CMD(CMD),
      .WR_DATA(WR_DATA), .ADDR_VALID(ADDR_VALID), .CMD_RDY(CMD_RDY), .halt(halt),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_ba(req_ba),
      .req_col(req_col), .req_cmd(req_cmd), .req_wdata(req_wdata), .ovf_err(ovf_err),
      .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance across one rising edge, landing on the next falling edge.
   task automatic step();
      @(negedge cpu_clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; ADDR_VALID = 1'b0; req_ready = 1'b0; halt = 1'b0;
      step(); step();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic prev_rdy;
      int   n;

      @(negedge cpu_clk);
      // Reset behaviour and reset-cycle outputs
      reset = 1'b1; ADDR_VALID = 1'b1;
      #1;
      check("rst_cmd_rdy", CMD_RDY, 0);
      check("rst_req_valid", req_valid, 0);
      step(); step();
      reset = 1'b0; ADDR_VALID = 1'b0;
      #1;
      check("post_rst_valid", req_valid, 0);
      check("post_rst_cmd_rdy", CMD_RDY, 1);
      check("post_rst_ovf", ovf_err, 0);
      check("post_rst_addr", req_addr, 0);
      check("post_rst_wdata", req_wdata, 0);
      check("post_rst_wr_cnt", wr_cnt, 0);
      check("post_rst_rd_cnt", rd_cnt, 0);

      // Single write request, visible the cycle after its push, popped next edge
      step();
      ADDR = 15'h1234; BA = 3'd5; COL = 10'h3FF; CMD = 1'b1; WR_DATA = 64'hDEAD_BEEF_0123_4567;
      ADDR_VALID = 1'b1; req_ready = 1'b1;
      step();
      ADDR_VALID = 1'b0;
      #1;
      check("single_valid", req_valid, 1);
      check("single_addr", req_addr, 15'h1234);
      check("single_ba", req_ba, 3'd5);
      check("single_col", req_col, 10'h3FF);
      check("single_cmd", req_cmd, 1);
      check("single_wdata", req_wdata, 64'hDEAD_BEEF_0123_4567);
      step();
      #1;
      check("single_popped", req_valid, 0);
      check("single_hold_addr", req_addr, 15'h1234);

      // CPU-style fill: ADDR_VALID follows CMD_RDY with one cycle of lag
      req_ready = 1'b0; CMD = 1'b0;
      prev_rdy = CMD_RDY;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         ADDR_VALID = prev_rdy;
         ADDR = 15'(100 + n);
         #1;
         if (ADDR_VALID) begin
            n++;
            if (n == 4) check("fill_rdy_drop_at3", CMD_RDY, 0);
            else        check("fill_rdy_high", CMD_RDY, 1);
         end
         prev_rdy = CMD_RDY;
         step();
      end
      ADDR_VALID = 1'b0;
      #1;
      check("fill_accepted", n, 4);
      check("fill_ovf", ovf_err, 0);
      check("fill_head", req_addr, 100);
      check("fill_cmd_rdy", CMD_RDY, 0);

      // Push and pop together while full, then drain: 8 entries in order
      req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ADDR = 15'(104 + i); ADDR_VALID = 1'b1;
         #1;
         check("full_pp_head", req_addr, 15'(100 + i));
         check("full_pp_valid", req_valid, 1);
         step();
      end
      ADDR_VALID = 1'b0;
      #1;
      check("full_pp_ovf", ovf_err, 0);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("drain_head", req_addr, 15'(104 + i));
         check("drain_valid", req_valid, 1);
         step();
      end
      #1;
      check("drain_empty", req_valid, 0);

      // Overflow: forced request into a full queue is dropped, flag sticks
      req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ADDR = 15'(200 + i); ADDR_VALID = 1'b1;
         step();
      end
      ADDR = 15'd299;
      step();
      ADDR_VALID = 1'b0;
      #1;
      check("ovf_set", ovf_err, 1);
      req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("ovf_drain_head", req_addr, 15'(200 + i));
         step();
      end
      #1;
      check("ovf_dropped", req_valid, 0);
      check("ovf_sticky", ovf_err, 1);
      do_reset();
      #1;
      check("ovf_cleared", ovf_err, 0);

      // Halt with two queued entries
      ADDR = 15'd300; ADDR_VALID = 1'b1;
      step();
      ADDR = 15'd301;
      step();
      ADDR_VALID = 1'b0; halt = 1'b1;
      step();
      req_ready = 1'b1;
      #1;
      check("halt_valid", req_valid, 0);
      check("halt_cmd_rdy", CMD_RDY, 0);
      step(); step();
      #1;
      check("halt_still_valid", req_valid, 0);
      halt = 1'b0;
      step();
      #1;
      check("resume_valid", req_valid, 1);
      check("resume_head0", req_addr, 300);
      step();
      #1;
      check("resume_head1", req_addr, 301);
      check("resume_valid1", req_valid, 1);
      step();
      #1;
      check("resume_empty", req_valid, 0);

      // Stats: 3 writes and 2 reads, then reset mid-stream
      do_reset();
      req_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ADDR = 15'(400 + i); CMD = (i % 2 == 0); ADDR_VALID = 1'b1;
         step();
      end
      ADDR_VALID = 1'b0;
      #1;
`ifdef DDR3_CONT_RX_STATS_EN
      check("stats_wr", wr_cnt, 3);
      check("stats_rd", rd_cnt, 2);
`else
      check("stats_wr_off", wr_cnt, 0);
      check("stats_rd_off", rd_cnt, 0);
`endif
      ADDR_VALID = 1'b1; req_ready = 1'b0; reset = 1'b1;
      #1;
      check("midrst_cmd_rdy", CMD_RDY, 0);
      check("midrst_valid", req_valid, 0);
      step();
      reset = 1'b0; ADDR_VALID = 1'b0;
      #1;
      check("midrst_wr", wr_cnt, 0);
      check("midrst_rd", rd_cnt, 0);
      check("midrst_after_valid", req_valid, 0);
      step();
      #1;
      check("midrst_still_empty", req_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ddr3_cont_cpu_rx.md
DDR3_CONT_CPU_RX -- requirements
Module: ddr3_cont_cpu_rx

Interface
REQ-001 Parameter DEPTH, default 4, request queue entries (power of two, >=2).
REQ-002 cpu_clk  in  1  sole clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ADDR  in  15  CPU row address.
REQ-005 BA  in  3  CPU bank address.
REQ-006 COL  in  10  CPU column address.
REQ-007 CMD  in  1  1=write, 0=read.
REQ-008 WR_DATA  in  64  write data (captured for reads, unused downstream).
REQ-009 ADDR_VALID  in  1  CPU request present this cycle; one request per high cycle.
REQ-010 CMD_RDY  out  1  receiver guarantees a free slot for a request arriving next cycle.
REQ-011 halt  in  1  freeze intake and issue, contents preserved.
REQ-012 req_valid  out  1  queue head valid toward scheduler.
REQ-013 req_ready  in  1  scheduler accepts head.
REQ-014 req_addr / req_ba / req_col / req_cmd / req_wdata  out  15/3/10/1/64  queue head fields.
REQ-015 ovf_err  out  1  sticky: request arrived with queue full.
REQ-016 wr_cnt / rd_cnt  out  16/16  accepted write/read counts (see Configuration).

Function
REQ-017 Queue is a DEPTH-entry FIFO of {ADDR,BA,COL,CMD,WR_DATA}, show-ahead: head fields drive req_* directly.
REQ-018 push = ADDR_VALID && (count<DEPTH || pop); pop = req_valid && req_ready.
REQ-019 count updates count+push-pop each cycle; pointers wrap modulo DEPTH.
REQ-020 Simultaneous push and pop at full: both occur, count stays DEPTH, new entry at tail.
REQ-021 Simultaneous push and pop at empty (count=0): push written, no pop (req_valid was 0), count becomes 1.
REQ-022 CMD_RDY combinational = (state==RUN) && (count + ADDR_VALID <= DEPTH-1); same-cycle pop ignored (conservative).
REQ-023 Request latency: entry pushed at edge N is visible on req_* with req_valid=1 after edge N when queue was empty.
REQ-024 req_valid = (count!=0) && (state==RUN).
REQ-025 ADDR_VALID with count=DEPTH and no pop: request dropped, ovf_err set, held until reset.
REQ-026 FSM states RUN, HOLD; RUN->HOLD when halt=1, HOLD->RUN when halt=0; transition takes effect on next edge.
REQ-027 In HOLD: CMD_RDY=0, req_valid=0, no pop; an ADDR_VALID arriving in the first HOLD cycle (promised by prior CMD_RDY) is still pushed if space exists, else ovf_err.
REQ-028 req_* data fields hold last head value when req_valid=0; not X after reset (zero).

Reset
REQ-029 reset=1 at an edge: count=0, pointers=0, state=RUN, ovf_err=0, wr_cnt=rd_cnt=0, storage zeroed; queued requests discarded.
REQ-030 During reset cycle CMD_RDY=0 and req_valid=0; ADDR_VALID ignored.
REQ-031 Reset mid-operation overrides any simultaneous push, pop or halt.

Configuration
REQ-032 Macro DDR3_CONT_RX_STATS_EN defined: wr_cnt/rd_cnt increment on each push with CMD=1/0, saturating at 16'hFFFF.
REQ-033 Macro undefined: counters not built, wr_cnt and rd_cnt tied to 0; all other behaviour identical.

Verification
REQ-034 Reset, then ADDR=15'h1234,BA=3'd5,COL=10'h3FF,CMD=1,ADDR_VALID one cycle, req_ready=1 -> next cycle req_valid=1, req_addr=15'h1234, req_ba=5, req_col=10'h3FF, req_cmd=1; pops following edge.
REQ-035 req_ready=0, ADDR_VALID held high while CMD_RDY high (CPU-style one-cycle lag) -> exactly 4 entries accepted, CMD_RDY drops with count=3 and ADDR_VALID=1, ovf_err stays 0.
REQ-036 Full queue, ADDR_VALID=1, req_ready=1 same cycle -> count stays 4, head advances, new entry lands at tail; 8 pushes total read back in order.
REQ-037 Full queue, req_ready=0, force ADDR_VALID=1 -> request dropped, ovf_err=1 until reset.
REQ-038 halt=1 with 2 entries, req_ready=1 -> req_valid=0, CMD_RDY=0, count 2 held; halt=0 -> both drain in order.
REQ-039 STATS_EN: 3 writes + 2 reads pushed -> wr_cnt=3, rd_cnt=2; reset mid-stream -> both 0, req_valid=0 next cycle.
